// File: rtl/alu_seq_if.sv
// alu_seq_if -- request/result bundle for the sequential ALU.
//   master : drives start, Arit, Op, Mul, A, B; observes results.
//   slave  : the ALU itself; drives R, z, c, s, v, busy, done.
// WIDTH must match the alu_seq instance it connects to.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             Arit;
    logic [1:0]       Op;
    logic             Mul;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] R;
    logic             z;
    logic             c;
    logic             s;
    logic             v;
    logic             busy;
    logic             done;

    modport master (
        output start, Arit, Op, Mul, A, B,
        input  R, z, c, s, v, busy, done
    );

    modport slave (
        input  start, Arit, Op, Mul, A, B,
        output R, z, c, s, v, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU: single-cycle add/sub/negate and logic ops,
// plus an optional WIDTH-cycle shift-add unsigned multiplier.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any operation)
//   bus   : alu_seq_if.slave -- start/Arit/Op/Mul/A/B in, R/z/c/s/v/busy/done out
// Build option: define ALU_SEQ_MUL_EN to include the multiplier (Mul=1).
// Without it Mul is ignored and the MUL state does not exist.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    alu_seq_if.slave  bus
);
    localparam logic [WIDTH:0]   ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam int               MSB  = WIDTH - 1;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
    localparam int CW = $clog2(WIDTH + 1);
`else
    typedef enum logic [1:0] {IDLE, EXEC} state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, r_q;
    logic [1:0]       op_q;
    logic             arit_q;
    logic             z_q, c_q, s_q, v_q, busy_q, done_q;

    // Single-cycle result computed from the captured operands.
    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] r_d;
    logic             z_d, c_d, s_d, v_d;

    always_comb begin
        sum_d = '0;
        r_d   = '0;
        c_d   = 1'b0;
        s_d   = 1'b0;
        v_d   = 1'b0;
        if (arit_q) begin
            case (op_q)
                2'b00:   sum_d = {1'b0, a_q} + {1'b0, b_q};
                2'b01:   sum_d = {1'b0, a_q} + {1'b0, ~b_q} + ONE;
                2'b10:   sum_d = {1'b0, ~a_q} + ONE;
                default: sum_d = {1'b0, ~b_q} + ONE;
            endcase
            r_d = sum_d[WIDTH-1:0];
            c_d = sum_d[WIDTH];
            s_d = r_d[MSB];
            // Overflow from operand/result sign bits; negation only
            // overflows on the most negative value.
            case (op_q)
                2'b00:   v_d = (a_q[MSB] == b_q[MSB]) && (r_d[MSB] != a_q[MSB]);
                2'b01:   v_d = (a_q[MSB] != b_q[MSB]) && (r_d[MSB] != a_q[MSB]);
                2'b10:   v_d = (a_q == SMIN);
                default: v_d = (b_q == SMIN);
            endcase
        end else begin
            case (op_q)
                2'b00:   r_d = a_q & b_q;
                2'b01:   r_d = a_q | b_q;
                2'b10:   r_d = a_q ^ b_q;
                default: r_d = ~a_q;
            endcase
        end
        z_d = (r_d == '0);
    end

`ifdef ALU_SEQ_MUL_EN
    // p_q = {partial high half, remaining multiplier bits}; each step adds A
    // into the high half when the current multiplier LSB is set, then shifts.
    logic [2*WIDTH-1:0] p_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     psum;

    always_comb begin
        psum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    end
`else
    logic unused_mul;
    assign unused_mul = bus.Mul;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            arit_q  <= 1'b0;
            r_q     <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            s_q     <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            p_q     <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    a_q    <= bus.A;
                    b_q    <= bus.B;
                    op_q   <= bus.Op;
                    arit_q <= bus.Arit;
                    busy_q <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
                    if (bus.Mul) begin
                        state_q <= MUL;
                        p_q     <= {{WIDTH{1'b0}}, bus.B};
                        cnt_q   <= '0;
                    end else begin
                        state_q <= EXEC;
                    end
`else
                    state_q <= EXEC;
`endif
                end
                EXEC: begin
                    r_q     <= r_d;
                    z_q     <= z_d;
                    c_q     <= c_d;
                    s_q     <= s_d;
                    v_q     <= v_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
`ifdef ALU_SEQ_MUL_EN
                // WIDTH shift-add steps, then one edge to publish the result.
                MUL: if (cnt_q != CW'(WIDTH)) begin
                    p_q   <= {psum, p_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + CW'(1);
                end else begin
                    r_q     <= p_q[WIDTH-1:0];
                    z_q     <= (p_q[WIDTH-1:0] == '0);
                    c_q     <= |p_q[2*WIDTH-1:WIDTH];
                    s_q     <= p_q[WIDTH-1];
                    v_q     <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.R    = r_q;
    assign bus.z    = z_q;
    assign bus.c    = c_q;
    assign bus.s    = s_q;
    assign bus.v    = v_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, operand/result width in bits (legal range 4..32).
REQ-002 SHALL provide port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL provide port: Arit  input  1  1 = arithmetic group, 0 = logic group.
REQ-006 SHALL provide port: Op  input  2  arith: 00 A+B, 01 A-B, 10 -A, 11 -B; logic: 00 AND, 01 OR, 10 XOR, 11 NOT A.
REQ-007 SHALL provide port: Mul  input  1  1 = unsigned multiply A*B (overrides Arit/Op when the feature is compiled in).
REQ-008 SHALL provide ports: A, B  input  WIDTH  operands; captured on accepted start.
REQ-009 SHALL provide port: R  output  WIDTH  registered result.
REQ-010 SHALL provide ports: z, c, s, v  output  1 each  registered zero, carry, sign, signed-overflow flags.
REQ-011 SHALL provide ports: busy  output  1  operation in progress; done  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM IDLE -> EXEC (single-cycle ops) or IDLE -> MUL (multiply) -> IDLE; busy = 1 in every non-IDLE state.
REQ-013 SHALL capture A, B, Op, Arit, Mul at the edge where start=1 in IDLE; inputs changing afterwards SHALL NOT affect the result.
REQ-014 SHALL, for single-cycle ops, update R/flags and assert done in the cycle after the EXEC edge: start at edge k -> done=1 after edge k+1, busy=0 after edge k+1.
REQ-015 SHALL ignore start while busy=1 (no queuing, no corruption).
REQ-016 SHALL accept a new start in the same cycle done=1 (back-to-back throughput one op per 2 cycles).
REQ-017 SHALL compute arith ops as WIDTH+1-bit two's-complement: A+B; A-B = A+~B+1; -A = ~A+1; -B = ~B+1; c = bit WIDTH of that sum.
REQ-018 SHALL set z = (R==0), s = R[WIDTH-1], v = signed overflow of the add/sub (for -A/-B: v=1 only when operand = 100..0).
REQ-019 SHALL, for logic ops, update R and z, and drive c=s=v=0.
REQ-020 SHALL hold R and all flags unchanged between done pulses.

Reset
REQ-021 SHALL, while rst_n=0, force state IDLE, R=0, z=c=s=v=0, busy=0, done=0, multiplier registers cleared.
REQ-022 SHALL abort any in-progress operation on reset without asserting done; first start after release accepted normally.

Configuration
REQ-023 SHALL compile the multiplier only when macro ALU_SEQ_MUL_EN is defined.
REQ-024 SHALL, with ALU_SEQ_MUL_EN: Mul=1 runs shift-add for WIDTH cycles in MUL; done after edge k+WIDTH+1; R = product[WIDTH-1:0], c = (product[2WIDTH-1:WIDTH]!=0), z = (R==0), s = R[WIDTH-1], v=0.
REQ-025 SHALL, without ALU_SEQ_MUL_EN: Mul ignored, operation decoded from Arit/Op, MUL state absent.

Verification (WIDTH=8)
REQ-026 SHALL cover: Arit=1 Op=00 A=AA B=EE start -> next-cycle done, R=98 c=1 s=1 z=0 v=0.
REQ-027 SHALL cover: Arit=1 Op=01 A=5A B=5A -> R=00 z=1 c=1 s=0 v=0; then Op=11 B=EE -> R=12 c=0 z=0.
REQ-028 SHALL cover: Arit=1 Op=00 A=7F B=01 -> R=80 v=1 s=1 c=0; Arit=0 Op=10 A=AA B=CC -> R=66 c=s=v=0 z=0.
REQ-029 SHALL cover: start re-asserted with different operands while busy -> ignored, first result delivered unchanged.
REQ-030 SHALL cover (ALU_SEQ_MUL_EN): Mul=1 A=10 B=20 -> done after 9 cycles, R=00 z=1 c=1; rst_n low at cycle 4 -> no done, outputs zero.
